usr_ser_tx: RTL and testbench

USR_SER_TX -- requirements
Module: usr_ser_tx

---
 rtl/usr_pkg.sv | 14 +
 rtl/usr_ser_tx.sv | 102 ++++++++++
 tb/tb_usr_ser_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the usr serial blocks: transmitter FSM states and
// the bit-order encodings used on the dir input.
package usr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } tx_state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_ser_tx.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word on load&ready and
// emits it one bit per cycle, MSB-first or LSB-first, then pulses done.
module usr_ser_tx
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] pin,
    input  logic             load,
    input  logic             dir,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shreg_d = pin;
                    dir_d   = dir;
                    cnt_d   = CNT_LAST;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Shift toward the output end so the next bit lands in the tap
                if (dir_q == DIR_LSB_FIRST) begin
                    shreg_d = shreg_q >> 1;
                end else begin
                    shreg_d = shreg_q << 1;
                end
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ready      = 1'b0;
        busy       = 1'b0;
        sout_valid = 1'b0;
        sout       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_SHIFT: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout       = (dir_q == DIR_LSB_FIRST) ? shreg_q[0] : shreg_q[WIDTH-1];
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_usr_ser_tx.sv
// Directed bench for usr_ser_tx (WIDTH=4) with hand-computed serial streams.
module tb_usr_ser_tx;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] pin;
    logic       load;
    logic       dir;
    logic       ready, sout, sout_valid, busy, done;

    integer tests = 0;
    integer fails = 0;

    logic [3:0] lb_q;

    usr_ser_tx #(.WIDTH(4)) dut (
        .clk        (clk),
        .clear      (clear),
        .pin        (pin),
        .load       (load),
        .dir        (dir),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed output vector: {ready, busy, sout_valid, sout, done}
    function automatic logic [4:0] obs();
        return {ready, busy, sout_valid, sout, done};
    endfunction

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        tests = tests + 1;
        assert (got === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    localparam logic [4:0] IDLE_V = 5'b10000;
    localparam logic [4:0] DONE_V = 5'b00001;

    function automatic logic [4:0] bitv(input logic b);
        return {1'b0, 1'b1, 1'b1, b, 1'b0};
    endfunction

    // Accept w with bit order d, then check the 4 bits, the done pulse and the return to idle
    task automatic xfer(input string tag, input logic [3:0] w, input logic d,
                        input logic [3:0] exp_seq);
        pin  = w;
        dir  = d;
        load = 1'b1;
        step();
        load = 1'b0;
        pin  = ~w;
        dir  = ~d;
        for (int i = 3; i >= 0; i--) begin
            chk($sformatf("%s_bit%0d", tag, 3 - i), obs(), bitv(exp_seq[i]));
            step();
        end
        chk({tag, "_done"}, obs(), DONE_V);
        step();
        chk({tag, "_idle"}, obs(), IDLE_V);
    endtask

    initial begin
        clear = 1'b1;
        load  = 1'b0;
        pin   = 4'b0000;
        dir   = 1'b0;
        step();
        step();
        clear = 1'b0;
        chk("reset_idle", obs(), IDLE_V);

        xfer("msb_1011", 4'b1011, 1'b0, 4'b1011);
        xfer("lsb_1011", 4'b1011, 1'b1, 4'b1101);
        xfer("zero_word", 4'b0000, 1'b0, 4'b0000);
        xfer("lsb_0110", 4'b0110, 1'b1, 4'b0110);

        // load during SHIFT is ignored, as are pin/dir changes
        pin  = 4'b1011;
        dir  = 1'b0;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("ign_bit0", obs(), bitv(1'b1));
        step();
        chk("ign_bit1", obs(), bitv(1'b0));
        load = 1'b1;
        pin  = 4'b0110;
        dir  = 1'b1;
        step();
        load = 1'b0;
        chk("ign_bit2", obs(), bitv(1'b1));
        step();
        chk("ign_bit3", obs(), bitv(1'b1));
        step();
        chk("ign_done", obs(), DONE_V);
        step();
        chk("ign_idle", obs(), IDLE_V);
        step();
        chk("ign_stays_idle", obs(), IDLE_V);

        // clear mid-transfer aborts with no done pulse
        pin  = 4'b1011;
        dir  = 1'b0;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("abort_bit0", obs(), bitv(1'b1));
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("abort_idle", obs(), IDLE_V);
        step();
        chk("abort_no_done1", obs(), IDLE_V);
        step();
        chk("abort_no_done2", obs(), IDLE_V);

        // clear beats load in the same cycle
        pin   = 4'b1111;
        load  = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        load  = 1'b0;
        chk("clr_prio_idle", obs(), IDLE_V);
        step();
        chk("clr_prio_no_shift", obs(), IDLE_V);

        // load held high: back-to-back words with a 2-cycle gap
        pin  = 4'b1011;
        dir  = 1'b0;
        load = 1'b1;
        step();
        pin  = 4'b0110;
        chk("b2b_w0_bit0", obs(), bitv(1'b1));
        step();
        chk("b2b_w0_bit1", obs(), bitv(1'b0));
        step();
        chk("b2b_w0_bit2", obs(), bitv(1'b1));
        step();
        chk("b2b_w0_bit3", obs(), bitv(1'b1));
        step();
        chk("b2b_done", obs(), DONE_V);
        step();
        chk("b2b_gap_ready", obs(), IDLE_V);
        step();
        load = 1'b0;
        chk("b2b_w1_bit0", obs(), bitv(1'b0));
        step();
        chk("b2b_w1_bit1", obs(), bitv(1'b1));
        step();
        chk("b2b_w1_bit2", obs(), bitv(1'b1));
        step();
        chk("b2b_w1_bit3", obs(), bitv(1'b0));
        step();
        chk("b2b_w1_done", obs(), DONE_V);
        step();
        chk("b2b_w1_idle", obs(), IDLE_V);

        // Loopback into a shift-right register: serial bit enters at the MSB
        lb_q = 4'b0000;
        pin  = 4'b1101;
        dir  = 1'b1;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sout_valid) lb_q = {sout, lb_q[3:1]};
            step();
        end
        chk("loopback_q", {1'b0, lb_q}, 5'b01101);
        chk("loopback_done", obs(), DONE_V);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
